// File: rtl/fifo_ptr_status_if.sv
// Pointer/status bundle between a Gray pointer counter and its status stage.
// Carries the local and remote pointers in, and the synchronised pointer and status flags out.
// No handshake: all signals are level signals sampled on the local clock.
interface fifo_ptr_status_if #(
    parameter int n = 4
);
    logic         inc;
    logic [n-1:0] local_ptr;
    logic [n-1:0] remote_ptr;
    logic [n-1:0] sync_ptr;
    logic         flag;
    logic         almost_flag;
    logic [n-1:0] level;
    logic         err;

    // Counter side: drives the pointers and the request, observes status.
    modport master (
        output inc, local_ptr, remote_ptr,
        input  sync_ptr, flag, almost_flag, level, err
    );

    // Status stage side.
    modport slave (
        input  inc, local_ptr, remote_ptr,
        output sync_ptr, flag, almost_flag, level, err
    );
endinterface

// File: rtl/fifo_ptr_status.sv
// Async FIFO pointer compare/status stage: remote-pointer synchroniser, full/empty, level, almost, sticky error.
// Latency: flag is combinational from registers; level/almost_flag 1 cycle after a pointer change; sync_ptr SYNC_STAGES edges.
// Backpressure: flag is the gate for the local counter; a request while flag is set only latches err.
module fifo_ptr_status #(
    parameter int    n           = 4,
    parameter string SIDE        = "WRITE",
    parameter int    SYNC_STAGES = 2,
    parameter int    THRESH      = 2**(n-1) - 2
) (
    input  logic              clk,
    input  logic              rst,
    fifo_ptr_status_if.slave  bus
);

    localparam bit           IS_WRITE = (SIDE == "WRITE");
    localparam logic [n-1:0] THRESH_V = THRESH[n-1:0];

    logic [n-1:0] sync_q [SYNC_STAGES];
    logic [n-1:0] sync_ptr;
    logic [n-1:0] local_bin;
    logic [n-1:0] sync_bin;
    logic [n-1:0] next_level;
    logic         next_almost;
    logic         flag;
    logic [n-1:0] level_q;
    logic         almost_q;
    logic         err_q;

    function automatic logic [n-1:0] gray2bin(input logic [n-1:0] g);
        logic [n-1:0] b;
        b[n-1] = g[n-1];
        for (int i = n - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Plain flop chain for the remote pointer; nothing may sit between stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= bus.remote_ptr;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign sync_ptr = sync_q[SYNC_STAGES-1];

    // Full/empty straight from the two pointer registers so the counter is gated on the same edge it advances.
    // Occupancy and almost threshold are derived here and registered below.
    always_comb begin
        local_bin   = gray2bin(bus.local_ptr);
        sync_bin    = gray2bin(sync_ptr);
        flag        = 1'b0;
        next_level  = '0;
        next_almost = 1'b0;
        if (IS_WRITE) begin
            // Full: same low bits, opposite wrap bit (top two bits inverted in Gray form).
            flag        = (bus.local_ptr == {~sync_ptr[n-1:n-2], sync_ptr[n-3:0]});
            next_level  = local_bin - sync_bin;
            next_almost = (next_level >= THRESH_V);
        end else begin
            flag        = (bus.local_ptr == sync_ptr);
            next_level  = sync_bin - local_bin;
            next_almost = (next_level <= THRESH_V);
        end
    end

    // Level and almost flag share one register stage so they always agree.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q  <= '0;
            almost_q <= !IS_WRITE;
        end else begin
            level_q  <= next_level;
            almost_q <= next_almost;
        end
    end

    // Sticky record of any request made while the counter was blocked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (bus.inc && flag) begin
            err_q <= 1'b1;
        end
    end

    assign bus.sync_ptr    = sync_ptr;
    assign bus.flag        = flag;
    assign bus.almost_flag = almost_q;
    assign bus.level       = level_q;
    assign bus.err         = err_q;

endmodule

// File: tb/tb_fifo_ptr_status.sv
// Directed bench for the write-side and read-side status stages (n = 4).
// Inputs change 1 ns after a rising edge; outputs are sampled at least 1 ns after that.
// All expected values are hand-computed constants.
module tb_fifo_ptr_status;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fifo_ptr_status_if #(.n(4)) wr_if ();
    fifo_ptr_status_if #(.n(4)) rd_if ();

    fifo_ptr_status #(.n(4), .SIDE("WRITE"), .SYNC_STAGES(2), .THRESH(6)) u_wr (
        .clk (clk),
        .rst (rst),
        .bus (wr_if)
    );

    fifo_ptr_status #(.n(4), .SIDE("READ"), .SYNC_STAGES(2), .THRESH(2)) u_rd (
        .clk (clk),
        .rst (rst),
        .bus (rd_if)
    );

    // Gray codes for binary 0..8.
    logic [3:0] gray_tbl [9] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110,
                                 4'b0111, 4'b0101, 4'b0100, 4'b1100};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int cycles = 1);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    initial begin
        wr_if.inc = 1'b0; wr_if.local_ptr = '0; wr_if.remote_ptr = '0;
        rd_if.inc = 1'b0; rd_if.local_ptr = '0; rd_if.remote_ptr = '0;

        // Bring up, then build non-zero state so the async reset has something to clear.
        tick(2);
        rst = 1'b0;
        wr_if.remote_ptr = 4'b0001; wr_if.local_ptr = 4'b0011;
        rd_if.remote_ptr = 4'b0011; rd_if.local_ptr = 4'b0001;
        tick(4);
        check("pre_rst_wr_sync", wr_if.sync_ptr, 4'b0001);
        check("pre_rst_wr_level", wr_if.level, 1);
        check("pre_rst_rd_flag", rd_if.flag, 0);

        // Assert reset mid-clock; outputs must clear without waiting for an edge.
        @(posedge clk);
        #3;
        rst = 1'b1;
        wr_if.local_ptr = '0; wr_if.remote_ptr = '0;
        rd_if.local_ptr = '0; rd_if.remote_ptr = '0;
        #1;
        check("rst_wr_sync", wr_if.sync_ptr, 4'b0000);
        check("rst_wr_flag", wr_if.flag, 0);
        check("rst_wr_almost", wr_if.almost_flag, 0);
        check("rst_wr_level", wr_if.level, 0);
        check("rst_wr_err", wr_if.err, 0);
        check("rst_rd_sync", rd_if.sync_ptr, 4'b0000);
        check("rst_rd_flag", rd_if.flag, 1);
        check("rst_rd_almost", rd_if.almost_flag, 1);
        check("rst_rd_level", rd_if.level, 0);
        check("rst_rd_err", rd_if.err, 0);
        tick(1);
        rst = 1'b0;
        tick(2);

        // Write fill with remote held at 0: flag is immediate, level/almost one edge later.
        for (int k = 1; k <= 8; k++) begin
            wr_if.local_ptr = gray_tbl[k];
            #1;
            check($sformatf("fill_flag_%0d", k), wr_if.flag, (k == 8) ? 1 : 0);
            check($sformatf("fill_level_pre_%0d", k), wr_if.level, k - 1);
            tick(1);
            check($sformatf("fill_level_%0d", k), wr_if.level, k);
            check($sformatf("fill_almost_%0d", k), wr_if.almost_flag, (k >= 6) ? 1 : 0);
        end

        // Overflow: one illegal push latches err permanently.
        check("ovf_err_before", wr_if.err, 0);
        wr_if.inc = 1'b1;
        tick(1);
        wr_if.inc = 1'b0;
        check("ovf_err_set", wr_if.err, 1);
        for (int c = 0; c < 20; c++) begin
            tick(1);
            check($sformatf("ovf_err_hold_%0d", c), wr_if.err, 1);
        end

        // Synchroniser latency: remote release shows up exactly two edges later.
        wr_if.remote_ptr = 4'b0001;
        tick(1);
        check("sync_lat_e1_ptr", wr_if.sync_ptr, 4'b0000);
        check("sync_lat_e1_flag", wr_if.flag, 1);
        tick(1);
        check("sync_lat_e2_ptr", wr_if.sync_ptr, 4'b0001);
        check("sync_lat_e2_flag", wr_if.flag, 0);
        check("sync_lat_e2_level", wr_if.level, 8);
        tick(1);
        check("sync_lat_e3_level", wr_if.level, 7);
        check("sync_lat_e3_almost", wr_if.almost_flag, 1);
        check("sync_err_still", wr_if.err, 1);

        // Only reset clears err.
        @(posedge clk);
        #3;
        rst = 1'b1;
        wr_if.local_ptr = '0; wr_if.remote_ptr = '0;
        #1;
        check("err_cleared_by_rst", wr_if.err, 0);
        tick(1);
        rst = 1'b0;

        // Wrap-around: local bin 14 (1001), remote bin 10 (1111).
        wr_if.local_ptr  = 4'b1001;
        wr_if.remote_ptr = 4'b1111;
        tick(4);
        check("wrap_sync", wr_if.sync_ptr, 4'b1111);
        check("wrap_level_4", wr_if.level, 4);
        check("wrap_almost_4", wr_if.almost_flag, 0);
        check("wrap_flag_4", wr_if.flag, 0);
        wr_if.local_ptr = 4'b1000;  // bin 15
        tick(1);
        wr_if.local_ptr = 4'b0000;  // bin 0
        tick(1);
        wr_if.local_ptr = 4'b0001;  // bin 1
        tick(1);
        check("wrap_level_7", wr_if.level, 7);
        wr_if.local_ptr = 4'b0011;  // bin 2
        #1;
        check("wrap_flag_full", wr_if.flag, 1);
        tick(1);
        check("wrap_level_8", wr_if.level, 8);
        check("wrap_almost_8", wr_if.almost_flag, 1);

        // Read side: equal pointers mean empty; a pop while empty latches err.
        rd_if.local_ptr  = 4'b0110;
        rd_if.remote_ptr = 4'b0110;
        tick(3);
        check("rd_sync_eq", rd_if.sync_ptr, 4'b0110);
        check("rd_flag_empty", rd_if.flag, 1);
        check("rd_level_0", rd_if.level, 0);
        check("rd_almost_0", rd_if.almost_flag, 1);
        rd_if.inc = 1'b1;
        tick(1);
        rd_if.inc = 1'b0;
        check("rd_err_set", rd_if.err, 1);

        // Remote write pointer moves from bin 4 to bin 7 (Gray 0100).
        rd_if.remote_ptr = 4'b0100;
        tick(1);
        check("rd_e1_flag", rd_if.flag, 1);
        tick(1);
        check("rd_e2_flag", rd_if.flag, 0);
        check("rd_e2_level", rd_if.level, 0);
        tick(1);
        check("rd_e3_level", rd_if.level, 3);
        check("rd_e3_almost", rd_if.almost_flag, 0);
        check("rd_err_hold", rd_if.err, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_ptr_status.md
Name: fifo_ptr_status

Overview:
- Pointer-compare and status stage for the async FIFO. Sits directly downstream of the dual n-bit Gray pointer counter, in the same clock domain.
- Takes the local registered Gray pointer and the Gray pointer from the opposite domain.
- Synchronises the remote pointer and generates the full/empty flag, fill level, the almost flag and a sticky overflow/underflow error.
- The same module is instantiated once on the write side and once on the read side, selected by parameter.

Parameters:
- n, 4: pointer width in bits. FIFO depth is 2^(n-1). Minimum n = 3.
- SIDE, "WRITE": "WRITE" produces full / almost_full / overflow. "READ" produces empty / almost_empty / underflow.
- SYNC_STAGES, 2: flops in the remote-pointer synchroniser. Minimum 2.
- THRESH, 2^(n-1)-2: almost threshold, n bits. Applies as level >= THRESH on the WRITE side and level <= THRESH on the READ side.

Ports:
- clk, in, 1: local domain clock.
- rst, in, 1: asynchronous, active-high reset.
- inc, in, 1: push (WRITE) or pop (READ) request; the same signal that drives the local pointer counter.
- local_ptr, in, n: registered Gray pointer from the local counter.
- remote_ptr, in, n: Gray pointer from the opposite clock domain, asynchronous to clk.
- sync_ptr, out, n: remote pointer after the synchroniser.
- flag, out, 1: full (WRITE) or empty (READ).
- almost_flag, out, 1: almost_full (WRITE) or almost_empty (READ).
- level, out, n: occupancy as seen from this domain, range 0 to 2^(n-1).
- err, out, 1: sticky overflow (WRITE) or underflow (READ).

Behaviour:
- Reset (async assert, clk-synchronous release):
  - All synchroniser flops = 0, so sync_ptr = 0.
  - level = 0 and err = 0.
  - almost_flag = 0 on WRITE, 1 on READ.
  - flag after reset, which follows from the reset pointers: WRITE = 0, READ = 1.
- Synchroniser:
  - remote_ptr passes through SYNC_STAGES flops. sync_ptr is the last flop.
  - A remote change is visible on sync_ptr exactly SYNC_STAGES rising edges after it is stable at the first flop.
  - No logic is allowed between the stages.
- Gray-to-binary conversion: b[n-1] = g[n-1]; b[i] = b[i+1] XOR g[i]. It is applied combinationally to both local_ptr and sync_ptr.
- flag is combinational from registers only (local_ptr, sync_ptr), with no added latency, so it updates on the same edge the local pointer advances. This prevents overflow/underflow by a correctly gated counter.
  - WRITE: flag = (local_ptr == {~sync_ptr[n-1:n-2], sync_ptr[n-3:0]}).
  - READ: flag = (local_ptr == sync_ptr).
- level is registered with 1 cycle latency after the pointer change. Arithmetic is modulo 2^n, so it is correct across pointer wrap-around.
  - WRITE: level = bin(local_ptr) - bin(sync_ptr).
  - READ: level = bin(sync_ptr) - bin(local_ptr).
  - level is pessimistic by design: it overstates fill on WRITE and understates on READ, by synchroniser lag.
- almost_flag is registered alongside level, computed from the same next-level value, so it has the same latency as level.
  - WRITE: almost_flag = next_level >= THRESH.
  - READ: almost_flag = next_level <= THRESH.
- err sets on any rising edge where inc = 1 and flag = 1, and stays set until rst.
  - The counter gates the access, so the pointer does not move; err only records the illegal request.
- Simultaneous events:
  - A remote pointer release in the same cycle as a local inc while flag = 1 still sets err. The release is not yet visible.
  - A remote change and a local inc in the same cycle: both take effect independently; no priority is needed.
- Reset mid-operation: all outputs return to their reset values immediately (async). The synchroniser contents are discarded.

Test Plan:
1. Reset (n=4, SIDE=WRITE), assert rst mid-clock -> immediately sync_ptr=0000, flag=0, almost_flag=0, level=0, err=0. With SIDE=READ: flag=1, almost_flag=1.
2. WRITE fill: remote_ptr=0000 held, drive local_ptr through Gray 0..8 one step per clk -> level increments 1 cycle after each step; almost_flag=1 when level reaches 6; flag=1 as soon as local_ptr=1100; level=8.
3. Overflow: at full, inc=1 for one cycle -> err=1 and stays 1 over 20 further cycles with inc=0; cleared only by rst.
4. Sync latency: at full, change remote_ptr 0000->0001 -> sync_ptr=0001 exactly 2 edges later; flag=0 in that same cycle; level=7 one edge after that.
5. Wrap-around: local_ptr binary 14 (Gray 1001), remote binary 10 (Gray 1111) -> level=4. Advance local to binary 2 (Gray 0011) across the wrap -> level=8, flag=1.
6. READ side: local_ptr=sync_ptr=0110 -> flag=1. inc=1 -> err=1. Remote advances 3 Gray steps -> after 2 cycles flag=0, then level=3 next cycle, and almost_flag=0 with THRESH=2.
